alu_result_skid: RTL and testbench

- Two-entry skid buffer on the execute-stage result path.
- Sits directly downstream of the ALU logic/arith units, including the 32-bit bitwise OR, and feeds the writeback/bypass stage.
- Registers the ALU result, overflow bit, destination tag and a precomputed zero flag.
- Decouples ALU issue from writeback stalls with a valid/ready handshake, at full throughput and without a combinational ready path.

---
 rtl/alu_result_skid.sv | 119 +++++++++++
 tb/tb_alu_result_skid.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_skid.sv
// ---------------------------------------------------------------------------
// alu_result_skid
//   Two-entry skid buffer on the execute-stage result path. Captures the ALU
//   result, overflow bit, destination tag and a precomputed zero flag, and
//   hands them to writeback/bypass over a valid/ready handshake. in_ready is
//   a function of registered state only, so there is no combinational path
//   from out_ready back to the ALU issue logic.
//
// Ports
//   clock, reset_n      rising-edge clock, async active-low reset
//   flush               synchronous clear of both entries
//   in_valid/in_ready   upstream handshake (in_ready = ~skid_valid)
//   in_result/ovf/tag   ALU result payload
//   out_valid/out_ready downstream handshake (out_valid = main_valid)
//   out_result/ovf/tag  buffered payload from the main entry
//   out_zero            1 when buffered result is zero
//   count               occupancy, 0..2
// ---------------------------------------------------------------------------
module alu_result_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_ovf,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic [1:0]       count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic             zero;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;

    // Zero flag is computed once at capture so writeback sees it as a flop.
    always_comb begin
        in_entry.result = in_result;
        in_entry.ovf    = in_ovf;
        in_entry.tag    = in_tag;
        in_entry.zero   = ~(|in_result);
    end

    assign in_fire  = in_valid & ~skid_valid_q;
    assign out_fire = main_valid_q & out_ready;

    // Next-state: flush wins, then drain skid, then the main-only cases.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_fire) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (in_fire && out_fire) begin
                main_d = in_entry;
            end else if (in_fire) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Outputs decode directly from flops.
    assign in_ready   = ~skid_valid_q;
    assign out_valid  = main_valid_q;
    assign out_result = main_q.result;
    assign out_ovf    = main_q.ovf;
    assign out_tag    = main_q.tag;
    assign out_zero   = main_q.zero;
    assign count      = 2'(main_valid_q) + 2'(skid_valid_q);

endmodule

// File: tb/tb_alu_result_skid.sv
// ---------------------------------------------------------------------------
// tb_alu_result_skid
//   Scoreboard bench for alu_result_skid. Inputs change 1 time unit after
//   the rising edge; outputs and handshakes are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_result_skid;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 5;

    logic             clock;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_ovf;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic [1:0]       count;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic             zero;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rx  = 0;

    logic             stall_seen = 1'b0;
    logic [WIDTH-1:0] stall_result;
    logic             stall_ovf;
    logic [TAG_W-1:0] stall_tag;
    logic             stall_zero;

    alu_result_skid #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_ovf     (in_ovf),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .count      (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: pop on out_fire, drop everything on flush, push on in_fire.
    always @(negedge clock) begin
        if (reset_n) begin
            if (stall_seen && out_valid) begin
                check_eq("hold_result", 64'(out_result), 64'(stall_result));
                check_eq("hold_ovf",    64'(out_ovf),    64'(stall_ovf));
                check_eq("hold_tag",    64'(out_tag),    64'(stall_tag));
                check_eq("hold_zero",   64'(out_zero),   64'(stall_zero));
            end
            stall_seen   = out_valid && !out_ready && !flush;
            stall_result = out_result;
            stall_ovf    = out_ovf;
            stall_tag    = out_tag;
            stall_zero   = out_zero;

            if (out_valid && out_ready) begin
                n_rx++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_output", 64'(out_result), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("sb_result", 64'(out_result), 64'(e.result));
                    check_eq("sb_ovf",    64'(out_ovf),    64'(e.ovf));
                    check_eq("sb_tag",    64'(out_tag),    64'(e.tag));
                    check_eq("sb_zero",   64'(out_zero),   64'(e.zero));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                exp_t e;
                e.result = in_result;
                e.ovf    = in_ovf;
                e.tag    = in_tag;
                e.zero   = (in_result == '0);
                sb.push_back(e);
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] r, input logic o, input logic [TAG_W-1:0] t);
        in_valid  = 1'b1;
        in_result = r;
        in_ovf    = o;
        in_tag    = t;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_ovf    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        #3;
        check_eq("rst_out_valid",  64'(out_valid),  64'd0);
        check_eq("rst_out_result", 64'(out_result), 64'd0);
        check_eq("rst_out_zero",   64'(out_zero),   64'd0);
        check_eq("rst_count",      64'(count),      64'd0);
        check_eq("rst_in_ready",   64'(in_ready),   64'd1);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // Pass-through
        out_ready = 1'b1;
        send(32'h0000_00FF, 1'b0, 5'd3);
        cyc();
        in_valid = 1'b0;
        check_eq("pt_out_valid",  64'(out_valid),  64'd1);
        check_eq("pt_out_result", 64'(out_result), 64'hFF);
        check_eq("pt_out_tag",    64'(out_tag),    64'd3);
        check_eq("pt_out_zero",   64'(out_zero),   64'd0);
        check_eq("pt_count1",     64'(count),      64'd1);
        cyc();
        check_eq("pt_count0",     64'(count),      64'd0);

        // Backpressure fill
        out_ready = 1'b0;
        send(32'h1234_5678, 1'b1, 5'd7);
        cyc();
        send(32'h0000_0000, 1'b0, 5'd9);
        cyc();
        send(32'hC0C0_C0C0, 1'b0, 5'd11);
        check_eq("bp_count2",   64'(count),      64'd2);
        check_eq("bp_in_ready", 64'(in_ready),   64'd0);
        check_eq("bp_head_A",   64'(out_result), 64'h1234_5678);
        cyc();
        check_eq("bp_full_count", 64'(count),      64'd2);
        check_eq("bp_still_A",    64'(out_result), 64'h1234_5678);
        in_valid = 1'b0;
        cyc();

        // Drain order
        out_ready = 1'b1;
        check_eq("dr_in_ready_before", 64'(in_ready), 64'd0);
        cyc();
        check_eq("dr_in_ready_after", 64'(in_ready),   64'd1);
        check_eq("dr_head_B",         64'(out_result), 64'd0);
        check_eq("dr_zero_B",         64'(out_zero),   64'd1);
        check_eq("dr_count_B",        64'(count),      64'd1);
        cyc();
        check_eq("dr_empty",          64'(out_valid),  64'd0);
        check_eq("dr_count0",         64'(count),      64'd0);

        // Full throughput
        n_rx = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            send(WIDTH'(i), 1'(i & 1), TAG_W'(i));
            cyc();
            check_eq("tp_out_valid", 64'(out_valid),       64'd1);
            check_eq("tp_out_seq",   64'(out_result),      64'(i));
            check_eq("tp_count_le1", 64'(count > 2'd1),    64'd0);
            check_eq("tp_in_ready",  64'(in_ready),        64'd1);
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        check_eq("tp_rx_total", 64'(n_rx),      64'd100);
        check_eq("tp_sb_empty", 64'(sb.size()), 64'd0);

        // Flush with concurrent input
        out_ready = 1'b0;
        send(32'hAAAA_0001, 1'b0, 5'd1);
        cyc();
        send(32'hAAAA_0002, 1'b0, 5'd2);
        cyc();
        check_eq("fl_count2", 64'(count), 64'd2);
        send(32'hCAFE_F00D, 1'b1, 5'd31);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_count0",    64'(count),     64'd0);
        check_eq("fl_out_valid", 64'(out_valid), 64'd0);
        check_eq("fl_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        n_rx = 0;
        cyc();
        cyc();
        check_eq("fl_no_output", 64'(n_rx), 64'd0);

        // Async reset mid-cycle while full
        out_ready = 1'b0;
        send(32'h5555_0001, 1'b0, 5'd4);
        cyc();
        send(32'h5555_0002, 1'b1, 5'd5);
        cyc();
        in_valid = 1'b0;
        check_eq("ar_count2", 64'(count), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        check_eq("ar_out_valid",  64'(out_valid),  64'd0);
        check_eq("ar_count0",     64'(count),      64'd0);
        check_eq("ar_in_ready",   64'(in_ready),   64'd1);
        check_eq("ar_out_result", 64'(out_result), 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        send(32'hDEAD_BEEF, 1'b0, 5'd17);
        cyc();
        in_valid = 1'b0;
        check_eq("ar_new_valid",  64'(out_valid),  64'd1);
        check_eq("ar_new_result", 64'(out_result), 64'hDEAD_BEEF);
        check_eq("ar_new_tag",    64'(out_tag),    64'd17);
        cyc();
        cyc();
        check_eq("end_sb_empty",  64'(sb.size()), 64'd0);
        check_eq("end_count0",    64'(count),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
